// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST controller: port widths, FSM states,
// and the TPG/MISR feedback polynomials.
package bist_pkg;

   localparam int PI_W  = 35;
   localparam int PO_W  = 49;
   localparam int CNT_W = 16;

   // x^35 + x^2 + 1: feedback taken from bits 34 and 1
   localparam logic [PI_W-1:0] LFSR_TAPS = 35'h4_0000_0002;
   // x^49 + x^9 + 1: internal XOR into bits 9 and 0
   localparam logic [PO_W-1:0] MISR_TAPS = 49'h0_0000_0000_0201;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CUTRST,
      ST_RUN,
      ST_FLUSH,
      ST_CMP,
      ST_DONE
   } state_t;

   function automatic logic [PI_W-1:0] lfsr_next(input logic [PI_W-1:0] s);
      return {s[PI_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/bist_misr.sv
// 49-bit internal-XOR multiple-input signature register compacting CUT responses.
module bist_misr
   import bist_pkg::*;
#(
   parameter logic [PO_W-1:0] SEED = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_load,
   input  logic            i_en,
   input  logic [PO_W-1:0] i_data,
   output logic [PO_W-1:0] o_sig
);

   logic [PO_W-1:0] r_sig;

   always_ff @(posedge clk) begin
      if (rst || i_load) begin
         r_sig <= SEED;
      end else if (i_en) begin
         r_sig <= {r_sig[PO_W-2:0], 1'b0}
                ^ (r_sig[PO_W-1] ? MISR_TAPS : '0)
                ^ i_data;
      end
   end

   assign o_sig = r_sig;

endmodule

// File: rtl/bist_ctrl.sv
// Logic BIST controller: drives LFSR patterns into the CUT, compacts its responses
// in a MISR and compares the final signature against a golden value.
module bist_ctrl
   import bist_pkg::*;
#(
   parameter int unsigned      NUM_PATTERNS = 2000,
   parameter logic [PI_W-1:0]  LFSR_SEED    = 35'h0_0000_0001,
   parameter logic [PO_W-1:0]  MISR_SEED    = 49'h0,
   parameter logic [PO_W-1:0]  GOLDEN_SIG   = 49'h0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            bistmode,
   input  logic [PI_W-1:0] pi,
   input  logic [PO_W-1:0] cut_po,
   output logic [PI_W-1:0] cut_pi,
   output logic            cut_rst,
   output logic            bistdone,
   output logic            bistpass,
   output logic [PO_W-1:0] signature
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

   state_t          r_state;
   state_t          w_next;
   logic [PI_W-1:0] r_lfsr;
   logic [CNT_W-1:0] r_cnt;
   logic            r_done;
   logic            r_pass;
   logic            w_last;
   logic            w_step;
   logic            w_misr_en;
   logic            w_misr_load;
   logic [PO_W-1:0] w_sig;

   assign w_last = (r_cnt == LAST_CNT);

   always_comb begin
      w_next      = r_state;
      w_step      = 1'b0;
      w_misr_en   = 1'b0;
      w_misr_load = 1'b0;
      case (r_state)
         ST_IDLE:   if (bistmode) w_next = ST_CUTRST;
         ST_CUTRST: begin
            w_misr_load = 1'b1;
            w_next      = ST_RUN;
         end
         ST_RUN: begin
            // first RUN cycle sees the CUT still coming out of reset, so skip it
            w_misr_en = (r_cnt != '0);
            w_step    = !w_last;
            if (w_last) w_next = ST_FLUSH;
         end
         ST_FLUSH: begin
            w_misr_en = 1'b1;
            w_next    = ST_CMP;
         end
         ST_CMP:    w_next = ST_DONE;
         ST_DONE:   w_next = ST_DONE;
         default:   w_next = ST_IDLE;
      endcase
      if (!bistmode) w_next = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // LFSR stops on the last pattern so FLUSH keeps presenting it
   always_ff @(posedge clk) begin
      if (rst || r_state == ST_CUTRST) begin
         r_lfsr <= LFSR_SEED;
         r_cnt  <= '0;
      end else if (w_step) begin
         r_lfsr <= lfsr_next(r_lfsr);
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !bistmode) begin
         r_done <= 1'b0;
         r_pass <= 1'b0;
      end else if (r_state == ST_CMP) begin
         r_done <= 1'b1;
         r_pass <= (w_sig == GOLDEN_SIG);
      end else if (r_state != ST_DONE) begin
         r_done <= 1'b0;
         r_pass <= 1'b0;
      end
   end

   bist_misr #(
      .SEED (MISR_SEED)
   ) u_misr (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_misr_load),
      .i_en   (w_misr_en),
      .i_data (cut_po),
      .o_sig  (w_sig)
   );

   assign cut_pi    = (r_state == ST_IDLE) ? pi : r_lfsr;
   assign cut_rst   = rst | (r_state == ST_CUTRST);
   assign bistdone  = r_done;
   assign bistpass  = r_pass;
   assign signature = w_sig;

endmodule

// File: tb/tb_bist_ctrl.sv
// Bench for bist_ctrl: registered CUT model, reference signature computed from the
// pattern sequence, directed run/abort/reset scenarios with randomized functional inputs.
module tb_bist_ctrl;

   localparam int          NP    = 2000;
   localparam int          CHUNK = 50;
   localparam logic [34:0] SEED  = 35'h0_0000_0001;
   localparam logic [48:0] MSEED = 49'h0;

   function automatic logic [48:0] resp(input logic [34:0] p);
      return {p[13:0], p} ^ {p, p[34:21]};
   endfunction

   function automatic logic [34:0] tpg_step(input logic [34:0] p);
      return {p[33:0], p[34] ^ p[1]};
   endfunction

   // Signature over the responses to patterns 0..NP-1, optionally with output bit 0 stuck at 1
   function automatic logic [48:0] model_sig(input bit stuck);
      logic [34:0] p;
      logic [48:0] s;
      logic [48:0] r;
      p = SEED;
      s = MSEED;
      for (int a = 0; a < NP / CHUNK; a++) begin
         for (int b = 0; b < CHUNK; b++) begin
            r = resp(p);
            if (stuck) r[0] = 1'b1;
            s = {s[47:0], 1'b0} ^ (s[48] ? 49'h0_0000_0000_0201 : 49'h0) ^ r;
            p = tpg_step(p);
         end
      end
      return s;
   endfunction

   localparam logic [48:0] GOLD = model_sig(1'b0);

   logic        clk = 1'b0;
   logic        rst;
   logic        bistmode;
   logic [34:0] pi;
   logic [48:0] cut_po;
   logic [34:0] cut_pi;
   logic        cut_rst;
   logic        bistdone;
   logic        bistpass;
   logic [48:0] signature;
   logic        stuck;
   logic [48:0] r_cut;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bist_ctrl #(
      .NUM_PATTERNS (NP),
      .LFSR_SEED    (SEED),
      .MISR_SEED    (MSEED),
      .GOLDEN_SIG   (GOLD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bistmode  (bistmode),
      .pi        (pi),
      .cut_po    (cut_po),
      .cut_pi    (cut_pi),
      .cut_rst   (cut_rst),
      .bistdone  (bistdone),
      .bistpass  (bistpass),
      .signature (signature)
   );

   // CUT with one cycle of response latency
   always_ff @(posedge clk) begin
      if (cut_rst) r_cut <= '0;
      else         r_cut <= resp(cut_pi);
   end
   assign cut_po = r_cut | {48'b0, stuck};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rand_pi();
      pi = {3'($urandom), $urandom};
   endtask

   // Releases the controller into a run and follows it until bistdone or a cycle budget
   task automatic do_run(input string tag, input bit flt, output logic [48:0] sig_out);
      int          e;
      int          bad_pat;
      int          zero_pat;
      bit          seen;
      logic [34:0] p;
      stuck = flt;
      @(negedge clk);
      rst      = 1'b0;
      bistmode = 1'b1;
      rand_pi();
      p        = SEED;
      bad_pat  = 0;
      zero_pat = 0;
      seen     = 1'b0;
      e        = 0;
      while (!seen && e < NP + 20) begin
         @(posedge clk);
         #1;
         e++;
         if (e == 1) chk({tag, "_cutrst_hi"}, 64'(cut_rst), 64'd1);
         if (e == 2) chk({tag, "_cutrst_lo"}, 64'(cut_rst), 64'd0);
         if (e >= 2 && e <= NP + 1) begin
            if (cut_pi !== p) bad_pat++;
            if (cut_pi == 35'h0) zero_pat++;
            if (e <= NP) p = tpg_step(p);
         end
         if (e == NP + 2) chk({tag, "_flush_hold"}, 64'(cut_pi), 64'(p));
         if (bistdone) seen = 1'b1;
      end
      chk({tag, "_latency"}, 64'(e), 64'(NP + 4));
      chk({tag, "_patterns"}, 64'(bad_pat), 64'd0);
      chk({tag, "_lfsr_nonzero"}, 64'(zero_pat), 64'd0);
      chk({tag, "_sig"}, 64'(signature), 64'(model_sig(flt)));
      chk({tag, "_pass"}, 64'(bistpass), 64'(!flt));
      sig_out = signature;
   endtask

   initial begin
      logic [48:0] sig_a;
      logic [48:0] sig_b;
      logic [48:0] sig_f;
      logic [48:0] sig_r;
      rst      = 1'b1;
      bistmode = 1'b0;
      pi       = '0;
      stuck    = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_done", 64'(bistdone), 64'd0);
      chk("rst_pass", 64'(bistpass), 64'd0);
      chk("rst_cutrst", 64'(cut_rst), 64'd1);
      chk("rst_sig", 64'(signature), 64'(MSEED));

      // Functional mode: pins pass straight through, nothing completes
      rst = 1'b0;
      pi  = 35'h5_A5A5_A5A5;
      #1;
      chk("idle_passthru", 64'(cut_pi), 64'h5_A5A5_A5A5);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rand_pi();
         #1;
         chk("idle_rand_pi", 64'(cut_pi), 64'(pi));
      end
      repeat (40) @(negedge clk);
      chk("idle_no_done", 64'(bistdone), 64'd0);
      chk("idle_cutrst", 64'(cut_rst), 64'd0);

      // Fault-free run, then result held in DONE
      do_run("run1", 1'b0, sig_a);
      chk("gold_match", 64'(sig_a), 64'(GOLD));
      repeat (10) @(negedge clk);
      rand_pi();
      #1;
      chk("hold_done", 64'(bistdone), 64'd1);
      chk("hold_pass", 64'(bistpass), 64'd1);
      chk("hold_sig", 64'(signature), 64'(sig_a));
      chk("hold_cutpi_lfsr", 64'(cut_pi === pi && pi != cut_pi), 64'd0);

      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rstpulse_done", 64'(bistdone), 64'd0);
      chk("rstpulse_sig", 64'(signature), 64'(MSEED));

      do_run("run2", 1'b0, sig_b);
      chk("back_to_back", 64'(sig_b), 64'(sig_a));

      @(negedge clk);
      rst = 1'b1;
      do_run("fault", 1'b1, sig_f);

      // Leaving DONE via bistmode=0
      @(negedge clk);
      bistmode = 1'b0;
      rand_pi();
      @(posedge clk);
      #1;
      chk("exit_done", 64'(bistdone), 64'd0);
      chk("exit_pass", 64'(bistpass), 64'd0);
      chk("exit_cutpi", 64'(cut_pi), 64'(pi));

      // Abort at RUN cycle 100
      stuck = 1'b0;
      @(negedge clk);
      bistmode = 1'b1;
      repeat (101) @(posedge clk);
      @(negedge clk);
      bistmode = 1'b0;
      rand_pi();
      @(posedge clk);
      #1;
      chk("abort_done", 64'(bistdone), 64'd0);
      chk("abort_cutpi", 64'(cut_pi), 64'(pi));
      chk("abort_cutrst", 64'(cut_rst), 64'd0);
      repeat (NP + 10) @(negedge clk);
      chk("abort_stays_idle", 64'(bistdone), 64'd0);

      // Reset at RUN cycle 500, then a clean restart
      bistmode = 1'b1;
      repeat (501) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrun_rst_done", 64'(bistdone), 64'd0);
      chk("midrun_rst_sig", 64'(signature), 64'(MSEED));
      chk("midrun_rst_cutrst", 64'(cut_rst), 64'd1);
      do_run("restart", 1'b0, sig_r);
      chk("restart_sig", 64'(sig_r), 64'(sig_a));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
